// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types: decoded control bundle, ALU opcodes and
// the architectural zero register index.
package rv32_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_LUI  = 4'd10
   } alu_op_t;

   typedef struct packed {
      alu_op_t    alu_op;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic [2:0] funct3;
   } ctrl_t;

   localparam ctrl_t      CTRL_NOP = '0;
   localparam logic [4:0] REG_X0   = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: the ID instruction reads a register that the load
// currently in EX has not yet fetched from memory.
module hazard_detect
   import rv32_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       hazard
);

   logic rs1_hit, rs2_hit;

   // x0 is never written, so a load targeting it cannot create a dependency
   assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
   assign hazard  = id_valid && ex_valid && ex_mem_read && (ex_rd != REG_X0)
                    && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, EX-driven flush
// and saturating bubble/flush performance counters.
module id_ex_pipe
   import rv32_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  ctrl_t           id_ctrl,
   input  logic            flush_ex,
   input  logic            ex_stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output ctrl_t           ex_ctrl,
   output logic            stall_fd,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic hazard;

   hazard_detect u_hazard (
      .id_valid    (id_valid),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl.mem_read),
      .ex_rd       (ex_rd),
      .hazard      (hazard)
   );

   // A flushed ID slot is discarded, so it must not also be held in IF/ID
   assign stall_fd = (hazard && !flush_ex && !ex_stall) || ex_stall;

   always_ff @(posedge clk) begin
      if (!resetn || flush_ex || (!ex_stall && hazard)) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_ctrl     <= CTRL_NOP;
      end else if (!ex_stall) begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         ex_rs1_data <= id_rs1_data;
         ex_rs2_data <= id_rs2_data;
         ex_imm      <= id_imm;
         ex_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
      end
   end

   // Counters saturate rather than wrap so long runs never read as small
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else if (flush_ex) begin
         if (id_valid && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end else if (!ex_stall && hazard) begin
         if (bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Decode-to-execute pipeline register with integrated load-use hazard detection.
- Captures the register-file read data (readData1/readData2, valid before the next posedge) plus decoded control and immediate from ID.
- Presents them registered to EX.
- Generates the stall back to IF/ID, inserts bubbles, and handles flush on taken branch/jump from EX.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of bubble/flush performance counters.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1  in  5  source register 1 index.
- id_rs2  in  5  source register 2 index.
- id_uses_rs1  in  1  instruction reads rs1.
- id_uses_rs2  in  1  instruction reads rs2.
- id_rd  in  5  destination index.
- id_rs1_data  in  XLEN  register-file read data 1.
- id_rs2_data  in  XLEN  register-file read data 2.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  ctrl_t  decoded control: alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, funct3[2:0].
- flush_ex  in  1  EX resolved taken branch/jump; kill ID instruction.
- ex_stall  in  1  downstream cannot accept; hold EX register.
- ex_valid  out  1  EX register holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rs1  out  5  registered rs1 index (for forwarding).
- ex_rs2  out  5  registered rs2 index (for forwarding).
- ex_rd  out  5  registered destination index.
- ex_rs1_data  out  XLEN  registered operand 1.
- ex_rs2_data  out  XLEN  registered operand 2.
- ex_imm  out  XLEN  registered immediate.
- ex_ctrl  out  ctrl_t  registered control.
- stall_fd  out  1  combinational; hold PC and IF/ID register this cycle.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.
- flush_cnt  out  CNT_W  count of valid ID instructions killed by flush.

Behaviour:
- Reset (resetn=0 at posedge):
  - ex_valid=0; all ex_* data/index fields=0; ex_ctrl all-zero (NOP, reg_write=0, mem_read=0, mem_write=0).
  - bubble_cnt=0, flush_cnt=0.
  - Reset mid-operation discards the EX contents.
- Load-use hazard, combinational:
  - hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - stall_fd = hazard & ~flush_ex & ~ex_stall, OR ex_stall.
- Per-posedge update priority, highest first:
  1. Reset.
  2. flush_ex: ex_valid<=0, ex_ctrl<=0, other fields don't-care (zeroed). flush_cnt += id_valid. flush_ex overrides both ex_stall and hazard.
  3. ex_stall: all ex_* hold their values; counters hold.
  4. hazard: bubble inserted. ex_valid<=0, ex_ctrl<=0. ID instruction stays in ID via stall_fd. bubble_cnt+=1.
  5. Otherwise: load all ex_* from id_*. ex_valid<=id_valid. ex_ctrl<=id_ctrl when id_valid, else 0.
- Bubble duration: a hazard produces exactly one bubble. The next cycle the EX instruction is the bubble (mem_read=0), so the hazard clears and ID advances.
- rd=x0 never causes a hazard. A load to x0 with a consumer of x0 proceeds without a bubble.
- Invalid slot: id_valid=0 never raises hazard and never increments counters.
- Counters: saturate at all-ones; no wrap.
- Latency: one cycle ID→EX when no stall/hazard.
- Register-file read: data is sampled on the negedge of the same cycle, so a WB write at the preceding posedge is already visible. No WB→ID bypass is needed here.

Decomposition:
- Package rv32_pkg:
  - ctrl_t packed struct.
  - alu_op_t enum.
  - CTRL_NOP constant (all-zero).
  - REG_X0 = 5'd0.
- Sub-module hazard_detect: purely combinational; inputs ID indices/uses and EX rd/mem_read/valid; output hazard.
- The pipeline register and counters stay in id_ex_pipe.

Test Plan:
- Reset: hold resetn=0 two cycles with id_valid=1, id_ctrl.reg_write=1 → ex_valid=0, ex_ctrl=0, counters=0 after release.
- Normal flow: id_pc=0x100, rs1_data=0x11, rs2_data=0x22, imm=0xFFFFFFF0, valid=1 → next cycle ex_pc=0x100, ex_rs1_data=0x11, ex_rs2_data=0x22, ex_imm=0xFFFFFFF0, ex_valid=1, stall_fd=0.
- Load-use: EX holds lw with rd=5; ID holds add using rs1=5 →
  - stall_fd=1 that cycle;
  - next cycle ex_valid=0, bubble_cnt=1;
  - following cycle the add enters EX, stall_fd=0.
- x0 and non-use:
  - EX lw rd=0, ID rs1=0 → no stall.
  - EX lw rd=7, ID uses_rs2=0 with rs2=7 → no stall.
- Flush priority: flush_ex=1 together with a hazard and ex_stall=1 → next cycle ex_valid=0, flush_cnt=1, bubble_cnt unchanged.
- Stall hold: ex_stall=1 for 3 cycles while id_* changes → ex_* constant, stall_fd=1 throughout; on release, the ID values at that cycle load.
